// File: rtl/dca_matrix_row_aligner.sv
// Two-stage row aligner: captures a collected AXI row buffer, shifts the matrix row
// down to element 0, and emits it with row index, last-row / done pulses and a sticky error flag.
module dca_matrix_row_aligner #(
    parameter int BW_AXI_DATA      = 32,
    parameter int MAX_NUM_AXI_DATA = 4,
    parameter int BW_ELEMENT       = 8,
    parameter int NUM_ELEMENT      = 4,
    parameter int BW_BITADDR       = 32,
    parameter int BW_ROW_CNT       = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BW_AXI_DATA*MAX_NUM_AXI_DATA-1:0]   in_row_buffer,
    input  logic [BW_BITADDR+9:0]                     in_txn_info,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_ELEMENT*BW_ELEMENT-1:0]         out_row,
    output logic                                      out_last_row,
    output logic [BW_ROW_CNT-1:0]                     out_row_index,
    output logic                                      matrix_done,
    output logic                                      misalign_error
);

    localparam int BW_ROW_BUF = BW_AXI_DATA * MAX_NUM_AXI_DATA;
    localparam int BW_ROW     = NUM_ELEMENT * BW_ELEMENT;
    localparam int BW_INFO    = BW_BITADDR + 10;
    localparam int BW_OFF     = $clog2(BW_AXI_DATA);
    localparam int ELEM_SH    = $clog2(BW_ELEMENT);
    localparam int BW_BUF_IDX = $clog2(BW_ROW_BUF);
    localparam logic [BW_OFF-1:0] ELEM_MASK = BW_OFF'(BW_ELEMENT - 1);

    // Stage A (capture)
    logic                   a_valid_reg;
    logic [BW_ROW_BUF-1:0]  a_buf_reg;
    logic [BW_INFO-1:0]     a_info_reg;

    // Stage B (output)
    logic                   b_valid_reg;
    logic [BW_ROW-1:0]      b_row_reg;
    logic                   b_last_reg;
    logic [BW_ROW_CNT-1:0]  b_index_reg;
    logic [BW_ROW_CNT-1:0]  row_cnt_reg;
    logic                   done_reg;
    logic                   misalign_reg;

    logic                   a_dummy;
    logic                   a_last;
    logic [7:0]             a_alen;
    logic [BW_OFF-1:0]      off;
    logic [BW_OFF-1:0]      off_elem;
    logic                   off_misaligned;
    logic                   alen_overflow;
    logic [BW_ROW-1:0]      aligned_row;
    logic [BW_BUF_IDX-1:0]  elem_base [NUM_ELEMENT];

    logic                   move;
    logic                   in_accept;
    logic                   out_accept;

    assign a_dummy = a_info_reg[BW_BITADDR+9];
    assign a_last  = a_info_reg[BW_BITADDR+8];
    assign a_alen  = a_info_reg[BW_BITADDR+7 -: 8];
    assign off     = BW_OFF'(a_info_reg[BW_BITADDR-1:0] % BW_BITADDR'(BW_AXI_DATA));

    // Dropping the sub-element bits rounds a misaligned offset down to an element boundary.
    assign off_elem       = off >> ELEM_SH;
    assign off_misaligned = (off & ELEM_MASK) != '0;
    assign alen_overflow  = ({1'b0, a_alen} + 9'd1) > 9'(MAX_NUM_AXI_DATA);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMENT; gi++) begin : g_elem
            assign elem_base[gi] = BW_BUF_IDX'((int'(off_elem) + gi) * BW_ELEMENT);
            assign aligned_row[gi*BW_ELEMENT +: BW_ELEMENT] = a_buf_reg[elem_base[gi] +: BW_ELEMENT];
        end
    endgenerate

    assign move       = a_valid_reg & (~b_valid_reg | out_ready) & enable;
    assign in_ready   = ~a_valid_reg | move;
    assign in_accept  = in_valid & in_ready & enable;
    assign out_accept = b_valid_reg & out_ready & enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_reg  <= 1'b0;
            a_buf_reg    <= '0;
            a_info_reg   <= '0;
            b_valid_reg  <= 1'b0;
            b_row_reg    <= '0;
            b_last_reg   <= 1'b0;
            b_index_reg  <= '0;
            row_cnt_reg  <= '0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            // Free-running so the pulse never stretches across a disabled cycle.
            done_reg <= out_accept & b_last_reg;

            if (in_accept) begin
                a_buf_reg  <= in_row_buffer;
                a_info_reg <= in_txn_info;
            end
            if (in_accept) begin
                a_valid_reg <= 1'b1;
            end else if (move) begin
                a_valid_reg <= 1'b0;
            end

            if (move) begin
                b_valid_reg <= 1'b1;
                b_row_reg   <= a_dummy ? '0 : aligned_row;
                b_last_reg  <= a_last;
                b_index_reg <= row_cnt_reg;
                row_cnt_reg <= a_last ? '0 : row_cnt_reg + BW_ROW_CNT'(1);
                if (!a_dummy && (off_misaligned || alen_overflow)) begin
                    misalign_reg <= 1'b1;
                end
            end else if (out_accept) begin
                b_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid      = b_valid_reg;
    assign out_row        = b_row_reg;
    assign out_last_row   = b_last_reg;
    assign out_row_index  = b_index_reg;
    assign matrix_done    = done_reg;
    assign misalign_error = misalign_reg;

endmodule

// File: tb/tb_dca_matrix_row_aligner.sv
// Directed bench for dca_matrix_row_aligner: a cycle table for streaming, alignment and
// dummy rows, then hand sequences for backpressure, reset-while-full, alen overflow and enable.
module tb_dca_matrix_row_aligner;

    localparam logic [127:0] BUF_A = 128'hCCBBAA99_88776655_44332211_DDCCBBAA;
    localparam logic [127:0] BUF_B = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_row_buffer;
    logic [41:0]  in_txn_info;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_row;
    logic         out_last_row;
    logic [7:0]   out_row_index;
    logic         matrix_done;
    logic         misalign_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dca_matrix_row_aligner #(
        .BW_AXI_DATA(32), .MAX_NUM_AXI_DATA(4), .BW_ELEMENT(8),
        .NUM_ELEMENT(4), .BW_BITADDR(32), .BW_ROW_CNT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row_buffer(in_row_buffer), .in_txn_info(in_txn_info),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last_row(out_last_row), .out_row_index(out_row_index),
        .matrix_done(matrix_done), .misalign_error(misalign_error)
    );

    typedef struct {
        string       name;
        logic        iv, en, rdy, sel, last, dummy;
        logic [7:0]  alen;
        logic [31:0] addr;
        logic        e_ir, e_ov, chk_data;
        logic [31:0] e_row;
        logic        e_last;
        logic [7:0]  e_idx;
        logic        e_done, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic iv, logic sel, logic last, logic dummy,
                                logic [31:0] addr, logic e_ir, logic e_ov, logic chk_data,
                                logic [31:0] e_row, logic e_last, logic [7:0] e_idx,
                                logic e_done, logic e_mis);
        vec_t v;
        v.name = name; v.iv = iv; v.en = 1'b1; v.rdy = 1'b1; v.sel = sel;
        v.last = last; v.dummy = dummy; v.alen = 8'd1; v.addr = addr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.chk_data = chk_data; v.e_row = e_row;
        v.e_last = e_last; v.e_idx = e_idx; v.e_done = e_done; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic apply(input logic iv, input logic en, input logic rdy, input logic sel,
                         input logic last, input logic dummy, input logic [7:0] alen,
                         input logic [31:0] addr);
        in_valid      = iv;
        enable        = en;
        out_ready     = rdy;
        in_row_buffer = sel ? BUF_B : BUF_A;
        in_txn_info   = {dummy, last, alen, addr};
    endtask

    task automatic chk1(input string name, input string field, input logic [31:0] got,
                        input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", name, field, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic ir, input logic ov, input logic cd,
                              input logic [31:0] row, input logic lst, input logic [7:0] idx,
                              input logic done, input logic mis);
        #1;
        chk1(name, "in_ready", {31'd0, in_ready}, {31'd0, ir});
        chk1(name, "out_valid", {31'd0, out_valid}, {31'd0, ov});
        chk1(name, "matrix_done", {31'd0, matrix_done}, {31'd0, done});
        chk1(name, "misalign_error", {31'd0, misalign_error}, {31'd0, mis});
        if (cd) begin
            chk1(name, "out_row", out_row, row);
            chk1(name, "out_last_row", {31'd0, out_last_row}, {31'd0, lst});
            chk1(name, "out_row_index", {24'd0, out_row_index}, {24'd0, idx});
        end
        $display("[%0t] %s in_ready=%b out_valid=%b row=%h idx=%0d done=%b err=%b",
                 $time, name, in_ready, out_valid, out_row, out_row_index, matrix_done,
                 misalign_error);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // name, iv, sel(1=B), last, dummy, addr | ir, ov, chk, row, last, idx, done, mis
        vecs.push_back(mk("reset",        0, 0, 0, 0, 32'h00, 1, 0, 1, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t1_in",        1, 0, 1, 0, 32'h10, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t1_stage_a",   0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t1_out",       0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h2211DDCC, 1, 0, 0, 0));
        vecs.push_back(mk("t2_r0",        1, 1, 0, 0, 32'h00, 1, 0, 0, 32'h0,        0, 0, 1, 0));
        vecs.push_back(mk("t2_r1",        1, 1, 0, 0, 32'h08, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t2_r2",        1, 1, 0, 0, 32'h10, 1, 1, 1, 32'h03020100, 0, 0, 0, 0));
        vecs.push_back(mk("t2_r3",        1, 1, 1, 0, 32'h18, 1, 1, 1, 32'h04030201, 0, 1, 0, 0));
        vecs.push_back(mk("t2_out2",      0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h05040302, 0, 2, 0, 0));
        vecs.push_back(mk("t2_out3",      0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h06050403, 1, 3, 0, 0));
        vecs.push_back(mk("t2_next_in",   1, 0, 0, 0, 32'h30, 1, 0, 0, 32'h0,        0, 0, 1, 0));
        vecs.push_back(mk("t2_next_a",    0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t2_next_out",  0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h2211DDCC, 0, 0, 0, 0));
        vecs.push_back(mk("t4_dummy_in",  1, 0, 0, 1, 32'h0C, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t4_mis_in",    1, 0, 0, 0, 32'h0C, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("t4_dummy_out", 0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h0,        0, 1, 0, 0));
        vecs.push_back(mk("t4_mis_out",   0, 0, 0, 0, 32'h00, 1, 1, 1, 32'h11DDCCBB, 0, 2, 0, 1));
        vecs.push_back(mk("t4_idle",      0, 0, 0, 0, 32'h00, 1, 0, 0, 32'h0,        0, 0, 0, 1));

        rst = 1'b1;
        apply(0, 1, 1, 0, 0, 0, 8'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].iv, vecs[i].en, vecs[i].rdy, vecs[i].sel, vecs[i].last,
                  vecs[i].dummy, vecs[i].alen, vecs[i].addr);
            expect_out(vecs[i].name, vecs[i].e_ir, vecs[i].e_ov, vecs[i].chk_data,
                       vecs[i].e_row, vecs[i].e_last, vecs[i].e_idx, vecs[i].e_done,
                       vecs[i].e_mis);
            tick();
        end

        // Backpressure: out_ready low for 5 cycles while three rows are offered (counter at 3).
        apply(1, 1, 0, 1, 0, 0, 8'd1, 32'h00); expect_out("t3_x_in", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        apply(1, 1, 0, 1, 0, 0, 8'd1, 32'h08); expect_out("t3_y_in", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 1, 0, 0, 8'd1, 32'h10);
            expect_out("t3_stall", 0, 1, 1, 32'h03020100, 0, 8'd3, 0, 1);
            tick();
        end
        apply(1, 1, 1, 1, 0, 0, 8'd1, 32'h10); expect_out("t3_release", 1, 1, 1, 32'h03020100, 0, 8'd3, 0, 1); tick();
        apply(0, 1, 1, 1, 0, 0, 8'd1, 32'h00); expect_out("t3_out_y", 1, 1, 1, 32'h04030201, 0, 8'd4, 0, 1); tick();
        expect_out("t3_out_z", 1, 1, 1, 32'h05040302, 0, 8'd5, 0, 1); tick();
        expect_out("t3_drained", 1, 0, 0, 0, 0, 0, 0, 1); tick();

        // Reset with both stages full (counter at 6).
        apply(1, 1, 0, 0, 0, 0, 8'd1, 32'h00); expect_out("t5_fill_a", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        apply(1, 1, 0, 0, 0, 0, 8'd1, 32'h08); expect_out("t5_fill_b", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        expect_out("t5_full", 0, 1, 1, 32'hDDCCBBAA, 0, 8'd6, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply(0, 1, 1, 0, 0, 0, 8'd0, 32'h00); expect_out("t5_after_rst", 1, 0, 1, 32'h0, 0, 8'd0, 0, 0); tick();

        // alen within range, then alen one beat too many.
        apply(1, 1, 1, 1, 0, 0, 8'd3, 32'h10); expect_out("alen_ok_in", 1, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 1, 1, 1, 0, 0, 8'd4, 32'h00); expect_out("alen_bad_in", 1, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 1, 0, 0, 0, 8'd0, 32'h00); expect_out("alen_ok_out", 1, 1, 1, 32'h05040302, 0, 8'd0, 0, 0); tick();
        expect_out("alen_bad_out", 1, 1, 1, 32'h03020100, 0, 8'd1, 0, 1); tick();
        expect_out("alen_idle", 1, 0, 0, 0, 0, 0, 0, 1); tick();

        // Clock enable low: nothing moves, nothing is accepted (counter at 2).
        apply(1, 1, 1, 0, 0, 0, 8'd1, 32'h00); expect_out("t6_w_in", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 1, 0, 0, 0, 8'd1, 32'h08);
            expect_out("t6_disabled", 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        apply(1, 1, 1, 0, 0, 0, 8'd1, 32'h08); expect_out("t6_reenable", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 1, 0, 0, 0, 8'd1, 32'h00);
            expect_out("t6_b_held", 0, 1, 1, 32'hDDCCBBAA, 0, 8'd2, 0, 1);
            tick();
        end
        apply(0, 1, 1, 0, 0, 0, 8'd1, 32'h00); expect_out("t6_w_out", 1, 1, 1, 32'hDDCCBBAA, 0, 8'd2, 0, 1); tick();
        expect_out("t6_v_out", 1, 1, 1, 32'h11DDCCBB, 0, 8'd3, 0, 1); tick();
        apply(1, 1, 1, 1, 1, 0, 8'd1, 32'h00); expect_out("t6_last_in", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        apply(0, 1, 1, 0, 0, 0, 8'd1, 32'h00); expect_out("t6_last_a", 1, 0, 0, 0, 0, 0, 0, 1); tick();
        expect_out("t6_last_out", 1, 1, 1, 32'h03020100, 1, 8'd4, 0, 1); tick();
        expect_out("t6_done", 1, 0, 0, 0, 0, 0, 1, 1); tick();
        expect_out("t6_done_clear", 1, 0, 0, 0, 0, 0, 0, 1); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
